// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and sizes for the two-port memory arbiter.
//               Holds the arbiter FSM state encoding and the bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 16;
  localparam int OFFS_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_XFER  = 2'd3
  } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_2p_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_2p_if
// Description : Bus bundle between two caches, main memory and the arbiter.
//   slave  modport : arbiter side (takes cache requests / memory responses,
//                    drives routed data, memory request, grant and busy).
//   master modport : environment side (caches and main memory).
//   Signals per cache N: pN_req, pN_wren, pN_address, pN_to_mem (to arbiter),
//   pN_from_mem, pN_offset, pN_ready (from arbiter).
//   Memory: mem_req, mem_wren, mem_address, to_mem (from arbiter),
//   from_mem, mem_offset, mem_ready (to arbiter). Status: grant, busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_2p_if;
  import mem_arb_pkg::*;

  logic              p0_req;
  logic              p0_wren;
  logic [ADDR_W-1:0] p0_address;
  logic [DATA_W-1:0] p0_to_mem;
  logic [DATA_W-1:0] p0_from_mem;
  logic [OFFS_W-1:0] p0_offset;
  logic              p0_ready;

  logic              p1_req;
  logic              p1_wren;
  logic [ADDR_W-1:0] p1_address;
  logic [DATA_W-1:0] p1_to_mem;
  logic [DATA_W-1:0] p1_from_mem;
  logic [OFFS_W-1:0] p1_offset;
  logic              p1_ready;

  logic              mem_req;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] to_mem;
  logic [DATA_W-1:0] from_mem;
  logic [OFFS_W-1:0] mem_offset;
  logic              mem_ready;

  logic [NUM_PORTS-1:0] grant;
  logic                 busy;

  modport slave (
    input  p0_req, p0_wren, p0_address, p0_to_mem,
    input  p1_req, p1_wren, p1_address, p1_to_mem,
    input  from_mem, mem_offset, mem_ready,
    output p0_from_mem, p0_offset, p0_ready,
    output p1_from_mem, p1_offset, p1_ready,
    output mem_req, mem_wren, mem_address, to_mem,
    output grant, busy
  );

  modport master (
    output p0_req, p0_wren, p0_address, p0_to_mem,
    output p1_req, p1_wren, p1_address, p1_to_mem,
    output from_mem, mem_offset, mem_ready,
    input  p0_from_mem, p0_offset, p0_ready,
    input  p1_from_mem, p1_offset, p1_ready,
    input  mem_req, mem_wren, mem_address, to_mem,
    input  grant, busy
  );

endinterface : mem_arbiter_2p_if
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin selector (purely combinational).
//   pending_i [1:0] : ports with an outstanding request
//   last_i    [0:0] : index of the port served most recently
//   pick_o    [1:0] : one-hot winner, 2'b00 when nothing is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] pending_i,
  input  logic [0:0] last_i,
  output logic [1:0] pick_o
);

  // A single pending bit is already one-hot; only a tie needs the history.
  always_comb begin
    pick_o = pending_i;
    if (&pending_i) begin
      pick_o = last_i[0] ? 2'b01 : 2'b10;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_2p
// Description : Round-robin arbiter sharing one burst memory between two
//               caches. Request pulses are captured into pending bits and
//               hold registers; the FSM (IDLE/ISSUE/WAIT/XFER) issues one
//               mem_req per burst and routes the burst to the granted port.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_2p_if.slave (cache, memory, grant and busy signals)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_2p
  import mem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_2p_if.slave bus
);

  arb_state_t           state_q;
  logic [NUM_PORTS-1:0] pending_q;
  logic [NUM_PORTS-1:0] pending_d;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] hold_wren_q;
  logic [ADDR_W-1:0]    hold_addr_q [NUM_PORTS];
  logic                 last_q;
  logic                 mem_req_q;
  logic                 busy_q;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_wren;
  logic [ADDR_W-1:0]    w_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_cap;
  logic [NUM_PORTS-1:0] w_clr;
  logic [NUM_PORTS-1:0] w_route;
  logic [NUM_PORTS-1:0] w_pick;
  logic                 w_done;
  logic                 w_burst_phase;

  assign w_req     = {bus.p1_req,  bus.p0_req};
  assign w_wren    = {bus.p1_wren, bus.p0_wren};
  assign w_addr[0] = bus.p0_address;
  assign w_addr[1] = bus.p1_address;

  // Falling mem_ready while transferring closes the burst.
  assign w_done        = (state_q == ST_XFER) && !bus.mem_ready;
  // Memory responses are only meaningful once the request has been issued.
  assign w_burst_phase = (state_q == ST_WAIT) || (state_q == ST_XFER);

  // A request is taken only when its port has nothing pending, so the first
  // capture wins. Clearing one port never masks a capture on the other.
  generate
    for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
      assign w_cap[n]     = w_req[n] & ~pending_q[n];
      assign w_clr[n]     = w_done & grant_q[n];
      assign pending_d[n] = w_cap[n] | (pending_q[n] & ~w_clr[n]);
      assign w_route[n]   = grant_q[n] & w_burst_phase;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      hold_wren_q <= '0;
      for (int n = 0; n < NUM_PORTS; n++) begin
        hold_addr_q[n] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (w_cap[n]) begin
          hold_wren_q[n] <= w_wren[n];
          hold_addr_q[n] <= w_addr[n];
        end
      end
    end
  end

  rr_pick2 u_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .pick_o    (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= 1'b1;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            grant_q   <= w_pick;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!bus.mem_ready) begin
            last_q  <= grant_q[1];
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q   <= '0;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // grant_q is one-hot or zero, so an AND-OR mux yields 0 when idle.
  assign bus.mem_req     = mem_req_q;
  assign bus.busy        = busy_q;
  assign bus.grant       = grant_q;
  assign bus.mem_wren    = |(grant_q & hold_wren_q);
  assign bus.mem_address = ({ADDR_W{grant_q[0]}} & hold_addr_q[0])
                         | ({ADDR_W{grant_q[1]}} & hold_addr_q[1]);
  assign bus.to_mem      = ({DATA_W{grant_q[0]}} & bus.p0_to_mem)
                         | ({DATA_W{grant_q[1]}} & bus.p1_to_mem);

  assign bus.p0_ready    = bus.mem_ready & w_route[0];
  assign bus.p1_ready    = bus.mem_ready & w_route[1];
  assign bus.p0_offset   = bus.mem_offset & {OFFS_W{w_route[0]}};
  assign bus.p1_offset   = bus.mem_offset & {OFFS_W{w_route[1]}};
  assign bus.p0_from_mem = bus.from_mem & {DATA_W{w_route[0]}};
  assign bus.p1_from_mem = bus.from_mem & {DATA_W{w_route[1]}};

endmodule : mem_arbiter_2p
`default_nettype wire

// File: doc/mem_arbiter_2p.md
MEM_ARBITER_2P -- requirements
Module: mem_arbiter_2p

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 The port list SHALL be as follows:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- pN_req  in  1  one-cycle request pulse from cache N (N=0,1).
- pN_wren  in  1  1 = writeback burst, 0 = fetch burst; sampled with pN_req.
- pN_address  in  32  burst start word address; sampled with pN_req.
- pN_to_mem  in  16  write data from cache N; passed through live while N is granted.
- pN_from_mem  out  16  read data to cache N.
- pN_offset  out  2  word offset to cache N.
- pN_ready  out  1  burst-active indication to cache N.
- mem_req  out  1  one-cycle request pulse to main memory.
- mem_wren  out  1  direction of the issued burst.
- mem_address  out  32  address of the issued burst.
- to_mem  out  16  write data to main memory.
- from_mem  in  16  read data from main memory.
- mem_offset  in  2  current word offset from main memory.
- mem_ready  in  1  main memory burst active; a falling edge ends the burst.
- grant  out  2  one-hot owner of the memory; 2'b00 when idle.
- busy  out  1  1 in any state other than IDLE.

Function
REQ-003 A pN_req pulse SHALL set pending[N] and latch pN_wren/pN_address into per-port hold registers at that edge.
REQ-004 The FSM states SHALL be IDLE, ISSUE, WAIT and XFER.
REQ-005 IDLE with any pending bit set SHALL select one port, set grant and go to ISSUE.
REQ-006 The selection SHALL be round-robin: when both ports are pending, the port not served last SHALL win; when one port is pending, that port SHALL win.
REQ-007 ISSUE SHALL assert mem_req for exactly one cycle and then go to WAIT.
REQ-008 WAIT SHALL go to XFER on mem_ready=1.
REQ-009 XFER SHALL, on mem_ready=0, clear pending[granted], record the granted port as last-served, clear grant and return to IDLE.
REQ-010 mem_address/mem_wren SHALL equal the granted port's hold registers from ISSUE through XFER, and SHALL be 0 in IDLE.
REQ-011 Routing:
- to_mem SHALL be the granted port's pN_to_mem, and 0 when idle.
- pN_ready SHALL be mem_ready AND grant[N].
- pN_offset and pN_from_mem SHALL be mem_offset and from_mem, ANDed to 0 when N is not granted.
REQ-012 Latency: a pN_req arriving in IDLE with no other pending request SHALL produce mem_req two cycles later; a pending request SHALL wait at most one full foreign burst plus two cycles.
REQ-013 A pN_req in the same cycle as the XFER-completion clear of the other port SHALL be captured, and neither event SHALL be lost.
REQ-014 A pN_req while pending[N] is already set SHALL be ignored; the first capture wins.
REQ-015 A mem_ready pulse while in IDLE or ISSUE SHALL be ignored and SHALL NOT be routed to any port.

Reset
REQ-016 On rst the block SHALL go to IDLE immediately and SHALL clear pending, hold registers, grant, busy, mem_req, mem_wren, mem_address, to_mem and all pN_ outputs; last-served SHALL be set to port 1, so that port 0 wins the first tie.
REQ-017 A reset during WAIT or XFER SHALL abandon the burst; no request SHALL be reissued after reset.

Structure
REQ-018 The package mem_arb_pkg SHALL hold the state enum, NUM_PORTS=2, ADDR_W=32 and DATA_W=16.
REQ-019 The round-robin pick SHALL be one sub-module, rr_pick2, with inputs pending[1:0] and last[0:0] and a one-hot output; all else SHALL stay in mem_arbiter_2p.

Verification
REQ-020 Idle single request: p0_req with address 32'h0000_1230 and wren=0 -> mem_req 2 cycles later with mem_address 32'h0000_1230 and mem_wren=0; a 4-beat mem_ready burst with offsets 0..3 appears only on p0_ready/p0_offset; busy then returns to 0.
REQ-021 Simultaneous requests after reset: p0 and p1 pulse in the same cycle -> p0 is served first and p1 is issued in ISSUE right after p0's XFER ends; p1 is never ready during p0's burst.
REQ-022 Fairness: p0 and p1 request continuously for 6 bursts -> the grant sequence is 01,10,01,10,01,10.
REQ-023 Writeback passthrough: p1_req with wren=1 and p1_to_mem 16'hBEEF -> to_mem=16'hBEEF during XFER; p0_to_mem 16'h1111 never reaches to_mem.
REQ-024 Edge capture: a p1_req in the cycle p0's mem_ready falls -> the p1 burst issues at address 32'h0000_2000 and pending[1] is not lost.
REQ-025 Reset in XFER: rst asserted in the middle of a burst -> all outputs are 0 in the same cycle and no mem_req follows after rst deasserts.
